// File: rtl/rv_data_cache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache for the RV32IM MEM stage.
// Byte/half/word accesses from funct3, round-robin replacement, block-level memory handshake.
module rv_data_cache_assoc #(
    parameter int NUM_SETS        = 8,
    parameter int NUM_WAYS        = 2,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                                                   CLOCK,
    input  logic                                                   RESET,
    input  logic                                                   READ,
    input  logic                                                   WRITE,
    input  logic [2:0]                                             FUNCT3,
    input  logic [ADDR_WIDTH-1:0]                                  ADDRESS,
    input  logic [31:0]                                            WRITEDATA,
    output logic [31:0]                                            READDATA,
    output logic                                                   BUSYWAIT,
    output logic                                                   MISALIGNED,
    output logic                                                   MEM_READ,
    output logic                                                   MEM_WRITE,
    output logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK*4)-1:0]        MEM_BLOCK_ADDR,
    output logic [32*WORDS_PER_BLOCK-1:0]                          MEM_WRITEDATA,
    input  logic [32*WORDS_PER_BLOCK-1:0]                          MEM_READDATA,
    input  logic                                                   MEM_BUSYWAIT
);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK * 4);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int WORD_W   = OFFSET_W - 2;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_UPDATE} state_t;
    state_t r_state, w_next;

    logic [TAG_W-1:0]                   r_tag  [NUM_SETS][NUM_WAYS];
    logic [31:0]                        r_data [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  r_valid, r_dirty;
    logic [NUM_SETS-1:0][WAY_W-1:0]     r_rr;
    logic [WAY_W-1:0]                   r_vway;
    logic [INDEX_W-1:0]                 r_vidx;
    logic [TAG_W-1:0]                   r_rtag;
    logic                               r_vvalid;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [WORD_W-1:0]   w_word;
    logic                w_req, w_mis_raw, w_mis, w_hit, w_miss, w_write_hit;
    logic [NUM_WAYS-1:0] w_hit_vec;
    logic [WAY_W-1:0]    w_hit_way, w_victim;
    logic [31:0]         w_hit_word, w_wdata_rep, w_merged, w_load;
    logic [3:0]          w_be;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    assign w_index = ADDRESS[OFFSET_W +: INDEX_W];
    assign w_tag   = ADDRESS[ADDR_WIDTH-1 -: TAG_W];
    assign w_word  = ADDRESS[OFFSET_W-1:2];
    assign w_req   = READ | WRITE;

    // Store-only encodings 100/101 do not exist, so they are rejected like any undefined funct3.
    always_comb begin
        w_mis_raw = 1'b1;
        case (FUNCT3)
            3'b000:  w_mis_raw = 1'b0;
            3'b001:  w_mis_raw = ADDRESS[0];
            3'b010:  w_mis_raw = |ADDRESS[1:0];
            3'b100:  w_mis_raw = WRITE;
            3'b101:  w_mis_raw = WRITE | ADDRESS[0];
            default: w_mis_raw = 1'b1;
        endcase
    end
    assign w_mis = w_req & w_mis_raw;

    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_index][w] && (r_tag[w_index][w] == w_tag);
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        end
    end
    assign w_hit = |w_hit_vec;

    // Descending scan leaves the lowest-index invalid way; otherwise round-robin.
    always_comb begin
        w_victim = r_rr[w_index];
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!r_valid[w_index][w]) w_victim = WAY_W'(w);
    end

    assign w_hit_word  = r_data[w_index][w_hit_way][w_word];
    assign w_miss      = (r_state == S_IDLE) & w_req & ~w_mis & ~w_hit;
    assign w_write_hit = (r_state == S_IDLE) & WRITE & ~w_mis & w_hit;

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = WRITEDATA;
        case (FUNCT3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << ADDRESS[1:0];
                w_wdata_rep = {4{WRITEDATA[7:0]}};
            end
            2'b01: begin
                w_be        = ADDRESS[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{WRITEDATA[15:0]}};
            end
            default: ;
        endcase
        w_merged = w_hit_word;
        for (int b = 0; b < 4; b++)
            if (w_be[b]) w_merged[8*b +: 8] = w_wdata_rep[8*b +: 8];
    end

    always_comb begin
        w_byte = w_hit_word[{ADDRESS[1:0], 3'b000} +: 8];
        w_half = ADDRESS[1] ? w_hit_word[31:16] : w_hit_word[15:0];
        case (FUNCT3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_hit_word;
            3'b100:  w_load = {24'b0, w_byte};
            3'b101:  w_load = {16'b0, w_half};
            default: w_load = '0;
        endcase
    end

    assign READDATA   = ((r_state == S_IDLE) && READ && !WRITE && !w_mis && w_hit) ? w_load : '0;
    assign MISALIGNED = w_mis;
    assign BUSYWAIT   = (w_req & ~w_hit & ~w_mis) | (r_state != S_IDLE);

    always_comb begin
        w_next    = r_state;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        case (r_state)
            S_IDLE:
                if (w_miss)
                    w_next = (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim])
                             ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: begin
                MEM_WRITE = 1'b1;
                if (!MEM_BUSYWAIT) w_next = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) w_next = S_UPDATE;
            end
            S_UPDATE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign MEM_BLOCK_ADDR = (r_state == S_WRITEBACK) ? {r_tag[r_vidx][r_vway], r_vidx}
                                                     : {r_rtag, r_vidx};

    always_comb begin
        MEM_WRITEDATA = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++)
            MEM_WRITEDATA[32*k +: 32] = r_data[r_vidx][r_vway][k];
    end

    // Reset drops valid/dirty, so any dirty line mid-refill is simply lost.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_next;
            if (w_write_hit) r_dirty[w_index][w_hit_way] <= 1'b1;
            if (r_state == S_UPDATE) begin
                r_valid[r_vidx][r_vway] <= 1'b1;
                r_dirty[r_vidx][r_vway] <= 1'b0;
                if (r_vvalid) r_rr[r_vidx] <= (NUM_WAYS == 1) ? '0 : r_rr[r_vidx] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            if (w_miss) begin
                r_vway   <= w_victim;
                r_vidx   <= w_index;
                r_rtag   <= w_tag;
                r_vvalid <= r_valid[w_index][w_victim];
            end
            if (r_state == S_UPDATE) begin
                r_tag[r_vidx][r_vway] <= r_rtag;
                for (int k = 0; k < WORDS_PER_BLOCK; k++)
                    r_data[r_vidx][r_vway][k] <= MEM_READDATA[32*k +: 32];
            end else if (w_write_hit) begin
                r_data[w_index][w_hit_way][w_word] <= w_merged;
            end
        end
    end

    a_hit_onehot: assert property (@(posedge CLOCK) disable iff (!RESET) $onehot0(w_hit_vec));

endmodule

// File: tb/tb_rv_data_cache_assoc.sv
// Directed bench for rv_data_cache_assoc against a latency-5 block memory model
// preloaded with word[i] = 0x1000_0000 + i.
module tb_rv_data_cache_assoc;
    localparam int L = 5;

    logic         CLOCK = 1'b0;
    logic         RESET, READ, WRITE;
    logic [2:0]   FUNCT3;
    logic [31:0]  ADDRESS, WRITEDATA, READDATA;
    logic         BUSYWAIT, MISALIGNED, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]  MEM_BLOCK_ADDR;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;

    rv_data_cache_assoc dut (
        .CLOCK(CLOCK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNCT3(FUNCT3),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MISALIGNED(MISALIGNED), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLOCK = ~CLOCK;

    // Memory: unwritten words read as their preload pattern. A request is served after
    // L busy-inclusive cycles; a write-back costs one extra recovery cycle on the next request.
    logic [31:0] mem [1024];
    bit   [1023:0] wvalid;
    int   mcnt = 0;
    int   both_cnt = 0, mem_act = 0;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt != L - 1);

    always_comb begin
        MEM_READDATA = '0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = int'(MEM_BLOCK_ADDR[7:0]) * 4 + k;
            MEM_READDATA[32*k +: 32] = wvalid[idx] ? mem[idx] : 32'h1000_0000 + 32'(idx);
        end
    end

    always @(posedge CLOCK) begin
        if (MEM_READ | MEM_WRITE) begin
            if (!MEM_BUSYWAIT) begin
                if (MEM_WRITE)
                    for (int k = 0; k < 4; k++) begin
                        mem[int'(MEM_BLOCK_ADDR[7:0]) * 4 + k]    <= MEM_WRITEDATA[32*k +: 32];
                        wvalid[int'(MEM_BLOCK_ADDR[7:0]) * 4 + k] <= 1'b1;
                    end
                mcnt <= MEM_WRITE ? -1 : 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    always @(negedge CLOCK) begin
        if (MEM_READ && MEM_WRITE) both_cnt <= both_cnt + 1;
        if (MEM_READ || MEM_WRITE) mem_act  <= mem_act + 1;
    end

    int n_chk = 0, n_fail = 0;
    logic [27:0] last_raddr, last_waddr;
    logic [31:0] last_w0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that commits the access.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int stall, output logic [31:0] rdat, output logic mis);
        READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITEDATA = wd;
        stall = 0;
        @(negedge CLOCK);
        while (BUSYWAIT && stall < 100) begin
            stall++;
            if (MEM_READ) last_raddr = MEM_BLOCK_ADDR;
            if (MEM_WRITE) begin
                last_waddr = MEM_BLOCK_ADDR;
                last_w0    = MEM_WRITEDATA[31:0];
            end
            @(negedge CLOCK);
        end
        rdat = READDATA;
        mis  = MISALIGNED;
        @(posedge CLOCK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b1;
    endtask

    initial begin
        int st, act0;
        logic [31:0] rd;
        logic ms;

        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = '0; WRITEDATA = '0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_misaligned", 32'(MISALIGNED), 32'd0);
        check("rst_readdata", READDATA, 32'd0);
        @(posedge CLOCK); #1;
        RESET = 1'b1;

        // 1: clean miss then hit
        last_raddr = '1;
        access(1, 0, 3'b010, 32'h100, 0, st, rd, ms);
        check("t1_miss_stall", 32'(st), 32'd7);
        check("t1_alloc_addr", 32'(last_raddr), 32'h010);
        check("t1_miss_data", rd, 32'h1000_0040);
        access(1, 0, 3'b010, 32'h100, 0, st, rd, ms);
        check("t1_hit_stall", 32'(st), 32'd0);
        check("t1_hit_data", rd, 32'h1000_0040);

        // 2: store miss with allocate, then sub-word store/loads
        access(0, 1, 3'b010, 32'h200, 32'hABCD_1234, st, rd, ms);
        check("t2_sw_stall", 32'(st), 32'd7);
        access(0, 1, 3'b000, 32'h201, 32'h80, st, rd, ms);
        check("t2_sb_stall", 32'(st), 32'd0);
        access(1, 0, 3'b000, 32'h201, 0, st, rd, ms);
        check("t2_lb", rd, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h201, 0, st, rd, ms);
        check("t2_lbu", rd, 32'h0000_0080);
        access(1, 0, 3'b101, 32'h202, 0, st, rd, ms);
        check("t2_lhu", rd, 32'h0000_ABCD);
        access(1, 0, 3'b001, 32'h202, 0, st, rd, ms);
        check("t2_lh", rd, 32'hFFFF_ABCD);
        access(1, 0, 3'b010, 32'h200, 0, st, rd, ms);
        check("t2_lw", rd, 32'hABCD_8034);

        // 3: dirty eviction from a full set
        do_reset();
        access(1, 0, 3'b010, 32'h000, 0, st, rd, ms);
        check("t3_fill0_stall", 32'(st), 32'd7);
        access(1, 0, 3'b010, 32'h080, 0, st, rd, ms);
        check("t3_fill1_stall", 32'(st), 32'd7);
        check("t3_fill1_data", rd, 32'h1000_0020);
        access(0, 1, 3'b010, 32'h000, 32'h5, st, rd, ms);
        check("t3_sw_hit_stall", 32'(st), 32'd0);
        last_waddr = '1; last_w0 = '1;
        access(1, 0, 3'b010, 32'h100, 0, st, rd, ms);
        check("t3_dirty_stall", 32'(st), 32'd13);
        check("t3_wb_addr", 32'(last_waddr), 32'h000);
        check("t3_wb_word0", last_w0, 32'h5);
        check("t3_dirty_data", rd, 32'h1000_0040);
        access(1, 0, 3'b010, 32'h000, 0, st, rd, ms);
        check("t3_reload_stall", 32'(st), 32'd7);
        check("t3_reload_data", rd, 32'h5);

        // 4: misaligned and undefined accesses leave everything untouched
        act0 = mem_act;
        access(1, 0, 3'b001, 32'h103, 0, st, rd, ms);
        check("t4_lh_mis", 32'(ms), 32'd1);
        check("t4_lh_busy", 32'(st), 32'd0);
        check("t4_lh_data", rd, 32'd0);
        access(0, 1, 3'b010, 32'h102, 32'hDEAD_BEEF, st, rd, ms);
        check("t4_sw_mis", 32'(ms), 32'd1);
        check("t4_sw_busy", 32'(st), 32'd0);
        access(1, 0, 3'b011, 32'h100, 0, st, rd, ms);
        check("t4_undef_mis", 32'(ms), 32'd1);
        check("t4_no_mem", 32'(mem_act), 32'(act0));
        access(1, 0, 3'b010, 32'h100, 0, st, rd, ms);
        check("t4_keep_stall", 32'(st), 32'd0);
        check("t4_keep_data", rd, 32'h1000_0040);
        check("t4_keep_mis", 32'(ms), 32'd0);

        // 5: reset during allocate
        READ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h180;
        repeat (2) @(negedge CLOCK);
        check("t5_in_alloc", 32'(MEM_READ), 32'd1);
        check("t5_alloc_addr", 32'(MEM_BLOCK_ADDR), 32'h018);
        RESET = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b1; READ = 1'b0;
        @(negedge CLOCK);
        check("t5_mem_read", 32'(MEM_READ), 32'd0);
        check("t5_busywait", 32'(BUSYWAIT), 32'd0);
        check("t5_readdata", READDATA, 32'd0);
        @(posedge CLOCK); #1;
        access(1, 0, 3'b010, 32'h100, 0, st, rd, ms);
        check("t5_remiss_stall", 32'(st), 32'd7);
        check("t5_remiss_data", rd, 32'h1000_0040);

        // 6: READ and WRITE together act as a store
        access(1, 1, 3'b010, 32'h300, 32'h77, st, rd, ms);
        check("t6_both_stall", 32'(st), 32'd7);
        check("t6_both_rdata", rd, 32'd0);
        access(1, 0, 3'b010, 32'h300, 0, st, rd, ms);
        check("t6_lw_stall", 32'(st), 32'd0);
        check("t6_lw_data", rd, 32'h0000_0077);

        check("mem_rw_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rv_data_cache_assoc.md
Name: rv_data_cache_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache between the RV32IM MEM stage and the block-wide data memory. It is the successor to the direct-mapped word-only cache. It adds configurable sets, ways and block size, and round-robin replacement. It performs byte/half/word loads and stores decoded from funct3, with sign/zero extension and misalignment detection. The CPU side stalls the pipeline through BUSYWAIT; the memory side uses the existing block READ/WRITE/BUSYWAIT handshake.

Parameters:
NUM_SETS, 8, number of sets (power of 2, ≥2); INDEX_W = log2(NUM_SETS)
NUM_WAYS, 2, associativity (power of 2, 1..4)
WORDS_PER_BLOCK, 4, 32-bit words per block (power of 2, ≥2); OFFSET_W = log2(WORDS_PER_BLOCK*4)
ADDR_WIDTH, 32, CPU byte-address width; TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W

Ports:
CLOCK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous, active-low reset
READ  in  1  CPU load request
WRITE  in  1  CPU store request
FUNCT3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
ADDRESS  in  ADDR_WIDTH  byte address
WRITEDATA  in  32  store data, low bytes used for SB/SH
READDATA  out  32  extended load result
BUSYWAIT  out  1  CPU stall
MISALIGNED  out  1  access rejected as misaligned
MEM_READ  out  1  block fetch request
MEM_WRITE  out  1  block write-back request
MEM_BLOCK_ADDR  out  ADDR_WIDTH-OFFSET_W  block address
MEM_WRITEDATA  out  32*WORDS_PER_BLOCK  victim block
MEM_READDATA  in  32*WORDS_PER_BLOCK  fetched block
MEM_BUSYWAIT  in  1  memory busy

Behaviour:
- Reset (RESET==0 at a rising edge): all valid/dirty bits and round-robin pointers cleared; FSM→IDLE. MEM_READ, MEM_WRITE, BUSYWAIT, MISALIGNED are 0 and READDATA is 0 from the next cycle. Reset mid-WRITEBACK/ALLOCATE aborts; dirty data is discarded (documented, not an error).
- Request = READ|WRITE. If both are high, WRITE takes priority.
- Misalignment (combinational): half with ADDRESS[0]≠0, or word with ADDRESS[1:0]≠0. Then MISALIGNED=1, BUSYWAIT=0, READDATA=0, and no state change. An undefined FUNCT3 is treated as misaligned.
- Hit: valid && tag match in any way of the indexed set. A hit in more than one way must not occur (assertion).
- Read hit: READDATA is combinational in the same cycle. It is selected by ADDRESS[OFFSET_W-1:2] and the byte/half lane, then extended (LB/LH sign-extend, LBU/LHU zero-extend). BUSYWAIT=0.
- Write hit: BUSYWAIT=0. The byte-enabled merge into the hit word and dirty=1 are committed at the same rising edge.
- BUSYWAIT = (request & ~hit & ~MISALIGNED) | (state≠IDLE). It is combinational, so the stall is visible in the miss cycle.
- FSM states:
  - IDLE: on a miss, pick the victim: the lowest-index invalid way if any, else the way at the set's rr pointer. Latch the victim way, index, and request tag. Go to WRITEBACK if the victim is valid&dirty, else ALLOCATE.
  - WRITEBACK: MEM_WRITE=1, MEM_BLOCK_ADDR={victim tag,index}, MEM_WRITEDATA=victim block. Go to ALLOCATE on the first edge with MEM_BUSYWAIT==0 after entry.
  - ALLOCATE: MEM_READ=1, MEM_BLOCK_ADDR={request tag,index}. Go to UPDATE on an edge with MEM_BUSYWAIT==0.
  - UPDATE: write MEM_READDATA into the victim way; valid=1, dirty=0, tag updated; the set's rr pointer increments (mod NUM_WAYS) only when a valid line was evicted. Go to IDLE. The CPU request is then re-evaluated as a hit; a store merges and sets dirty on that hit.
- Memory handshake: MEM_READ and MEM_WRITE are never both high. Each is held stable until MEM_BUSYWAIT is seen low at a rising edge. The memory may take ≥1 cycle.
- Latency, with memory latency L cycles: read hit 0 stall cycles; clean miss L+2; dirty miss 2L+3.
- The CPU must hold READ/WRITE/ADDRESS/FUNCT3/WRITEDATA stable while BUSYWAIT=1.

Test Plan:
Test-plan configuration: defaults; memory model L=5; memory preloaded word[i]=0x1000_0000+i.
1. Reset, then LW 0x100 → BUSYWAIT=1 for 7 cycles, MEM_BLOCK_ADDR=0x010, READDATA=0x1000_0040. Repeat LW 0x100 → 0 stall.
2. SW 0xABCD_1234 @0x200 (miss, allocate) → stall 7. Then SB 0x80 @0x201 hits with no stall. LB 0x201 → 0xFFFF_FF80, LBU → 0x0000_0080, LHU 0x202 → 0x0000_ABCD.
3. Fill set 0: LW 0x000, 0x080, then a third tag (0x100). Way 0 is the dirty victim (after SW 0x5 @0x000) → WRITEBACK of block 0x000 with word0=5, then allocate; total stall 13.
4. LH 0x103 and SW 0x102 → MISALIGNED=1, BUSYWAIT=0, no MEM_READ/MEM_WRITE, cache contents unchanged.
5. RESET low for one edge during ALLOCATE → MEM_READ=0 next cycle, BUSYWAIT=0. Subsequent LW 0x100 misses again.
6. READ and WRITE both high, SW 0x77 @0x300 → treated as a store. A later LW 0x300 returns 0x0000_0077.
